gate_reduce_seq: RTL and testbench

Sequential, parametrised N-input multi-function gate evaluator for the logic-unit family. It accepts NUM_IN operands of WIDTH bits, one per cycle, over a valid/ready input stream and folds them into a bitwise AND/OR/NAND/NOR/XOR/XNOR result. The result is returned through a valid/ready output handshake. It generalises the fixed 2-input, 1-bit gates to arbitrary width, input count and selectable function, and sits between operand-sourcing logic and the datapath result bus.

---
 rtl/gate_pkg.sv | 32 +++
 rtl/gate_fold.sv | 25 ++
 rtl/gate_reduce_seq.sv | 116 +++++++++++
 tb/tb_gate_reduce_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate_reduce_seq logic-unit evaluator:
// function encodings, FSM state type and op classification helpers.
package gate_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return op <= OP_XNOR;
   endfunction

   // Inverting functions fold like their base gate and complement at the end.
   function automatic logic is_inverting(input logic [2:0] op);
      return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
   endfunction

   // AND-family folds start from all ones; every other family starts from zero.
   function automatic logic identity_is_ones(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

endpackage

// File: rtl/gate_fold.sv
// One folding step of the accumulator: combines the running value with a
// new operand using the base gate of the selected function.
module gate_fold
   import gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] in_data,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] acc_next
);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves acc_next unassigned (no latch).
      acc_next = acc;
      case (op)
         OP_AND, OP_NAND: acc_next = acc & in_data;
         OP_OR,  OP_NOR:  acc_next = acc | in_data;
         OP_XOR, OP_XNOR: acc_next = acc ^ in_data;
         default:         acc_next = acc;
      endcase
   end

endmodule

// File: rtl/gate_reduce_seq.sv
// Sequential N-input bitwise gate evaluator: accepts NUM_IN operands over a
// valid/ready stream, folds them, and returns the result over valid/ready.
module gate_reduce_seq
   import gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
);

   localparam int CNT_W = $clog2(NUM_IN + 1);

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   fold_acc;
   logic [CNT_W-1:0]   cnt_inc;
   logic               take_start;

   gate_fold #(.WIDTH(WIDTH)) u_fold (
      .acc      (acc_q),
      .in_data  (in_data),
      .op       (op_q),
      .acc_next (fold_acc)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   // A request is taken in IDLE, or in DONE on the cycle the result is accepted.
   assign take_start = (state_q == ST_IDLE) ||
                       ((state_q == ST_DONE) && out_ready && !abort);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: ;
         ST_ACCUM: begin
            if (abort) begin
               state_d = ST_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (in_valid) begin
               acc_d = fold_acc;
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(NUM_IN)) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (abort) begin
               state_d = ST_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (take_start && start) begin
         if (is_legal_op(op)) begin
            state_d = ST_ACCUM;
            op_d    = op;
            acc_d   = identity_is_ones(op) ? '1 : '0;
            cnt_d   = '0;
         end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_AND;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign err       = err_q;
   assign out_data  = out_valid ? (is_inverting(op_q) ? ~acc_q : acc_q) : '0;

endmodule

// File: tb/tb_gate_reduce_seq.sv
// Directed self-checking bench for gate_reduce_seq with a per-bit
// population-count reference model and a result scoreboard.
module tb_gate_reduce_seq;
   import gate_pkg::*;

   localparam int WIDTH  = 8;
   localparam int NUM_IN = 4;

   typedef logic [WIDTH-1:0] beats_t [NUM_IN];

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [2:0]       op = 3'b000;
   logic             abort = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready = 1'b0;
   logic             busy;
   logic             err;

   int checks = 0;
   int failures = 0;
   logic [2:0]       cur_op = 3'b000;
   logic [WIDTH-1:0] exp_q[$];
   logic             prev_illegal = 1'b0;
   beats_t           bv;

   gate_reduce_seq #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each result bit depends only on how many operands had that bit set.
   function automatic logic [WIDTH-1:0] model_eval(input logic [2:0] f, input beats_t b);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < WIDTH; k++) begin
         int ones = 0;
         for (int i = 0; i < NUM_IN; i++) ones += int'(b[i][k]);
         case (f)
            3'b000: r[k] = (ones == NUM_IN);
            3'b001: r[k] = (ones > 0);
            3'b010: r[k] = !(ones == NUM_IN);
            3'b011: r[k] = !(ones > 0);
            3'b100: r[k] = (ones % 2) == 1;
            default: r[k] = (ones % 2) == 0;
         endcase
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_illegal = 1'b0;
      end else begin
         check("err_pulse", {31'd0, err}, {31'd0, prev_illegal});
         check("busy_decode", {31'd0, busy}, {31'd0, in_ready | out_valid});
         check("ready_valid_excl", {31'd0, in_ready & out_valid}, 32'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               check("out_data_model", {24'd0, out_data}, {24'd0, exp_q[0]});
               if (out_ready && !abort) void'(exp_q.pop_front());
            end
         end
         prev_illegal = start && (op > 3'b101) &&
                        (!busy || (out_valid && out_ready && !abort));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [2:0] f);
      start  = 1'b1;
      op     = f;
      cur_op = f;
      tick();
      start = 1'b0;
      op    = 3'b000;
   endtask

   task automatic send_beat(input logic [WIDTH-1:0] d, input int gap);
      int n = 0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) check("beat_timeout", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic feed(input beats_t b, input int gap, input logic [WIDTH-1:0] lit, input string name);
      for (int i = 0; i < NUM_IN; i++) send_beat(b[i], gap);
      exp_q.push_back(model_eval(cur_op, b));
      check({name, "_latency"}, {31'd0, out_valid}, 32'd1);
      check(name, {24'd0, out_data}, {24'd0, lit});
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("drained_valid", {31'd0, out_valid}, 32'd0);
      check("drained_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      rst_n = 1'b1;
      tick();

      do_start(OP_NOR);
      check("accum_in_ready", {31'd0, in_ready}, 32'd1);
      bv = '{8'h0F, 8'hF0, 8'h00, 8'h00};
      feed(bv, 0, 8'h00, "nor_mix");
      drain();
      do_start(OP_NOR);
      bv = '{8'h00, 8'h00, 8'h00, 8'h00};
      feed(bv, 0, 8'hFF, "nor_zero");
      drain();

      do_start(OP_XOR);
      bv = '{8'h01, 8'h02, 8'h04, 8'h08};
      feed(bv, 2, 8'h0F, "xor_gaps");
      drain();
      do_start(OP_XNOR);
      feed(bv, 2, 8'hF0, "xnor_gaps");
      drain();

      for (int k = 6; k < 8; k++) begin
         do_start(3'(k));
         check("illegal_err", {31'd0, err}, 32'd1);
         check("illegal_in_ready", {31'd0, in_ready}, 32'd0);
         check("illegal_busy", {31'd0, busy}, 32'd0);
         tick();
         check("illegal_err_drop", {31'd0, err}, 32'd0);
      end

      do_start(OP_NAND);
      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      feed(bv, 0, 8'h00, "nand_ones");
      repeat (5) begin
         tick();
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_data", {24'd0, out_data}, 32'd0);
      end
      out_ready = 1'b1;
      start     = 1'b1;
      op        = OP_AND;
      cur_op    = OP_AND;
      tick();
      start = 1'b0;
      out_ready = 1'b0;
      check("accept_restart_ready", {31'd0, in_ready}, 32'd1);
      check("accept_restart_valid", {31'd0, out_valid}, 32'd0);
      bv = '{8'hF0, 8'h3C, 8'hFF, 8'hF7};
      feed(bv, 0, 8'h30, "and_after_restart");
      drain();

      out_ready = 1'b1;
      do_start(OP_XOR);
      bv = '{8'h11, 8'h22, 8'h44, 8'h80};
      feed(bv, 0, 8'hF7, "xor_b2b");
      start  = 1'b1;
      op     = OP_OR;
      cur_op = OP_OR;
      tick();
      start = 1'b0;
      check("b2b_no_bubble", {31'd0, in_ready}, 32'd1);
      bv = '{8'h01, 8'h02, 8'h00, 8'h00};
      feed(bv, 0, 8'h03, "or_b2b");
      drain();

      do_start(OP_AND);
      send_beat(8'h3C, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_err", {31'd0, err}, 32'd0);
      check("async_rst_out_data", {24'd0, out_data}, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      do_start(OP_OR);
      bv = '{8'hA0, 8'h05, 8'h00, 8'h00};
      feed(bv, 0, 8'hA5, "or_after_reset");
      drain();

      do_start(OP_XOR);
      send_beat(8'h12, 0);
      send_beat(8'h34, 0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      abort    = 1'b1;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_accum_busy", {31'd0, busy}, 32'd0);
      check("abort_accum_ready", {31'd0, in_ready}, 32'd0);
      check("abort_accum_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("abort_accum_err", {31'd0, err}, 32'd0);

      do_start(OP_OR);
      bv = '{8'h12, 8'h34, 8'h00, 8'h00};
      feed(bv, 0, 8'h36, "or_pre_abort");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      void'(exp_q.pop_front());
      check("abort_done_valid", {31'd0, out_valid}, 32'd0);
      check("abort_done_busy", {31'd0, busy}, 32'd0);

      do_start(OP_AND);
      bv = '{8'hFF, 8'h0F, 8'hFF, 8'h3F};
      feed(bv, 0, 8'h0F, "and_pre_abort");
      abort     = 1'b1;
      out_ready = 1'b1;
      tick();
      abort     = 1'b0;
      out_ready = 1'b0;
      void'(exp_q.pop_front());
      check("abort_prio_valid", {31'd0, out_valid}, 32'd0);
      check("abort_prio_busy", {31'd0, busy}, 32'd0);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      repeat (3) tick();
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
